// File: rtl/char_proj_pkg.sv
// Shared definitions for the character projection controller.
//   PIX_W        : pixel coordinate width (rows and columns)
//   ctrl_state_e : tracking FSM encoding (IDLE=0, ACQUIRE=1, LOCKED=2, HOLD=3)
//   abs_diff     : unsigned absolute difference, widened by one bit
package char_proj_pkg;

  localparam int unsigned PIX_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_HOLD    = 2'd3
  } ctrl_state_e;

  function automatic logic [PIX_W:0] abs_diff(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    logic [PIX_W:0] aw;
    logic [PIX_W:0] bw;
    aw = {1'b0, a};
    bw = {1'b0, b};
    return (aw >= bw) ? (aw - bw) : (bw - aw);
  endfunction

endpackage

// File: rtl/frame_sample_timer.sv
// Frame boundary detector and result-sample timer.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   vsync      : frame vsync input
//   fb         : frame boundary (registered vsync rising edge), one cycle
//   sample     : one-cycle strobe SAMPLE_DLY-1 cycles after fb
// A new fb while a sample is pending restarts the count, so the pending
// sample is dropped.
module frame_sample_timer #(
  parameter int unsigned SAMPLE_DLY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic fb,
  output logic sample
);

  localparam int unsigned TW = (SAMPLE_DLY < 2) ? 1 : $clog2(SAMPLE_DLY + 1);
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_DLY - 1);

  logic          vs_r_q, vs_r_d;
  logic          vs_r2_q, vs_r2_d;
  logic          active_q, active_d;
  logic [TW-1:0] tmr_q, tmr_d;

  // The fb cycle itself counts as timer value 0; tmr_q holds 1 on the cycle
  // after fb, so the strobe lands on the cycle where the count is SAMPLE_DLY-1.
  always_comb begin
    vs_r_d   = vsync;
    vs_r2_d  = vs_r_q;
    fb       = vs_r_q & ~vs_r2_q;
    active_d = active_q;
    tmr_d    = tmr_q;
    sample   = 1'b0;
    if (fb) begin
      if (SAMPLE_DLY <= 1) begin
        sample   = 1'b1;
        active_d = 1'b0;
        tmr_d    = '0;
      end else begin
        active_d = 1'b1;
        tmr_d    = TW'(1);
      end
    end else if (active_q) begin
      if (tmr_q == T_LAST) begin
        sample   = 1'b1;
        active_d = 1'b0;
        tmr_d    = '0;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r_q   <= 1'b0;
      vs_r2_q  <= 1'b0;
      active_q <= 1'b0;
      tmr_q    <= '0;
    end else begin
      vs_r_q   <= vs_r_d;
      vs_r2_q  <= vs_r2_d;
      active_q <= active_d;
      tmr_q    <= tmr_d;
    end
  end

endmodule

// File: rtl/char_projection_ctrl.sv
// Frame-level controller for the character horizontal-projection datapath.
//   clk, rst_n                 : pixel clock, asynchronous active-low reset
//   per_frame_vsync            : vsync of the projection input stream
//   plate_valid/left/right     : plate locator column bounds
//   proj_line_up/down          : projection upper/lower row results
//   horizon_start/end          : projection column window, updated per frame
//   char_top/bottom/valid      : debounced character band
//   ctrl_state                 : tracking FSM state (debug)
//   frame_done                 : one-cycle pulse per evaluated sample
module char_projection_ctrl
  import char_proj_pkg::*;
#(
  parameter int unsigned IMG_HDISP     = 640,
  parameter int unsigned IMG_VDISP     = 480,
  parameter int unsigned MARGIN        = 4,
  parameter int unsigned MIN_HEIGHT    = 10,
  parameter int unsigned MAX_HEIGHT    = 200,
  parameter int unsigned TOL           = 4,
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned LOST_FRAMES   = 5,
  parameter int unsigned SAMPLE_DLY    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             plate_valid,
  input  logic [PIX_W-1:0] plate_left,
  input  logic [PIX_W-1:0] plate_right,
  input  logic [PIX_W-1:0] proj_line_up,
  input  logic [PIX_W-1:0] proj_line_down,
  output logic [PIX_W-1:0] horizon_start,
  output logic [PIX_W-1:0] horizon_end,
  output logic [PIX_W-1:0] char_top,
  output logic [PIX_W-1:0] char_bottom,
  output logic             char_valid,
  output logic [1:0]       ctrl_state,
  output logic             frame_done
);

  localparam int unsigned W1 = PIX_W + 1;
  localparam int unsigned CW = $clog2(STABLE_FRAMES + 1);
  localparam int unsigned MW = $clog2(LOST_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_FRAMES - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOST_FRAMES - 1);

  logic fb;
  logic sample;

  frame_sample_timer #(
    .SAMPLE_DLY(SAMPLE_DLY)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .vsync (per_frame_vsync),
    .fb    (fb),
    .sample(sample)
  );

  logic [PIX_W-1:0] hs_q, hs_d;
  logic [PIX_W-1:0] he_q, he_d;
  logic             cfg_cur_q, cfg_cur_d;
  logic             cfg_prev_q, cfg_prev_d;
  ctrl_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [PIX_W-1:0] ref_u_q, ref_u_d;
  logic [PIX_W-1:0] ref_dn_q, ref_dn_d;
  logic [PIX_W-1:0] top_q, top_d;
  logic [PIX_W-1:0] bot_q, bot_d;
  logic             fd_q, fd_d;

  logic             plate_ok;
  logic [W1-1:0]    height;
  logic             good;
  logic             cons;
  logic             load_ref;
  logic             publish;
  logic [CW-1:0]    cnt_inc;
  logic [MW-1:0]    miss_inc;

  // Column window: latched only on the frame boundary.
  always_comb begin
    plate_ok   = plate_valid &
                 ({1'b0, plate_right} > ({1'b0, plate_left} + W1'(2 * MARGIN + 1)));
    hs_d       = hs_q;
    he_d       = he_q;
    cfg_cur_d  = cfg_cur_q;
    cfg_prev_d = cfg_prev_q;
    if (fb) begin
      cfg_prev_d = cfg_cur_q;
      if (plate_ok) begin
        hs_d      = plate_left + PIX_W'(MARGIN);
        he_d      = plate_right - PIX_W'(MARGIN);
        cfg_cur_d = 1'b1;
      end else begin
        hs_d      = '0;
        he_d      = PIX_W'(IMG_HDISP - 1);
        cfg_cur_d = 1'b0;
      end
    end
  end

  // Measurement qualification.
  always_comb begin
    height = {1'b0, proj_line_down} - {1'b0, proj_line_up};
    good   = cfg_prev_q &
             (proj_line_down > proj_line_up) &
             (height >= W1'(MIN_HEIGHT)) &
             (height <= W1'(MAX_HEIGHT)) &
             ({1'b0, proj_line_down} < W1'(IMG_VDISP));
    cons   = (abs_diff(proj_line_up, ref_u_q) <= W1'(TOL)) &
             (abs_diff(proj_line_down, ref_dn_q) <= W1'(TOL));
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    miss_inc = (miss_q == '1) ? miss_q : miss_q + MW'(1);
  end

  // Tracking FSM, advanced only on the sample strobe. Lock/lost tests use >=
  // so a saturated counter can never miss its exit condition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;
    ref_u_d  = ref_u_q;
    ref_dn_d = ref_dn_q;
    top_d    = top_q;
    bot_d    = bot_q;
    fd_d     = sample;
    load_ref = 1'b0;
    publish  = 1'b0;
    if (sample) begin
      case (state_q)
        ST_IDLE: begin
          if (good) begin
            load_ref = 1'b1;
            cnt_d    = CW'(1);
            if (STABLE_FRAMES <= 1) begin
              state_d = ST_LOCKED;
              publish = 1'b1;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end
        end
        ST_ACQUIRE: begin
          if (!good) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            load_ref = 1'b1;
            if (cons) begin
              cnt_d = cnt_inc;
              if (cnt_q >= CNT_LAST) begin
                state_d = ST_LOCKED;
                publish = 1'b1;
              end
            end else begin
              cnt_d = CW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (!good) begin
            state_d = ST_HOLD;
            miss_d  = MW'(1);
          end else begin
            load_ref = 1'b1;
            if (cons) begin
              publish = 1'b1;
            end else begin
              state_d = ST_ACQUIRE;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (!good) begin
            miss_d = miss_inc;
            if (miss_q >= MISS_LAST) state_d = ST_IDLE;
          end else begin
            load_ref = 1'b1;
            if (cons) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
              publish = 1'b1;
            end else begin
              state_d = ST_ACQUIRE;
              cnt_d   = CW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (load_ref) begin
        ref_u_d  = proj_line_up;
        ref_dn_d = proj_line_down;
      end
      if (publish) begin
        top_d = proj_line_up;
        bot_d = proj_line_down;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q       <= '0;
      he_q       <= PIX_W'(IMG_HDISP - 1);
      cfg_cur_q  <= 1'b0;
      cfg_prev_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      miss_q     <= '0;
      ref_u_q    <= '0;
      ref_dn_q   <= '0;
      top_q      <= '0;
      bot_q      <= '0;
      fd_q       <= 1'b0;
    end else begin
      hs_q       <= hs_d;
      he_q       <= he_d;
      cfg_cur_q  <= cfg_cur_d;
      cfg_prev_q <= cfg_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      ref_u_q    <= ref_u_d;
      ref_dn_q   <= ref_dn_d;
      top_q      <= top_d;
      bot_q      <= bot_d;
      fd_q       <= fd_d;
    end
  end

  assign horizon_start = hs_q;
  assign horizon_end   = he_q;
  assign char_top      = top_q;
  assign char_bottom   = bot_q;
  assign char_valid    = (state_q == ST_LOCKED) | (state_q == ST_HOLD);
  assign ctrl_state    = state_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_char_projection_ctrl.sv
// Bench for char_projection_ctrl: event-scheduled behavioural model checked
// every cycle, plus literal checks for the documented scenarios.
module tb_char_projection_ctrl;

  localparam int DLY = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0;
  logic       pv = 1'b0;
  logic [9:0] pl = '0;
  logic [9:0] pr = '0;
  logic [9:0] pu = '0;
  logic [9:0] pd = '0;
  logic [9:0] hs, he, ctop, cbot;
  logic       cvalid, fdone;
  logic [1:0] cstate;

  always #5 clk = ~clk;

  char_projection_ctrl #(
    .IMG_HDISP(640), .IMG_VDISP(480), .MARGIN(4), .MIN_HEIGHT(10),
    .MAX_HEIGHT(200), .TOL(4), .STABLE_FRAMES(3), .LOST_FRAMES(5),
    .SAMPLE_DLY(DLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs),
    .plate_valid(pv), .plate_left(pl), .plate_right(pr),
    .proj_line_up(pu), .proj_line_down(pd),
    .horizon_start(hs), .horizon_end(he),
    .char_top(ctop), .char_bottom(cbot), .char_valid(cvalid),
    .ctrl_state(cstate), .frame_done(fdone)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model. Tracking states: 0 idle, 1 acquire, 2 locked, 3 hold.
  int m_state, m_cnt, m_miss, m_ru, m_rd, m_top, m_bot;
  int m_hs, m_he, m_fd, m_cc, m_cp, m_prev_vs, m_pend, m_tgt, m_n;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic m_reset();
    m_state = 0; m_cnt = 0; m_miss = 0; m_ru = 0; m_rd = 0;
    m_top = 0; m_bot = 0; m_hs = 0; m_he = 639; m_fd = 0;
    m_cc = 0; m_cp = 0; m_prev_vs = 0; m_pend = 0; m_tgt = -1; m_n = 0;
  endtask

  task automatic m_sample(input int u, input int d);
    bit good, cons;
    good = (m_cp != 0) && (d > u) && (d - u >= 10) && (d - u <= 200) && (d < 480);
    cons = (iabs(u - m_ru) <= 4) && (iabs(d - m_rd) <= 4);
    if (!good) begin
      if (m_state == 1) begin m_state = 0; m_cnt = 0; end
      else if (m_state == 2) begin m_state = 3; m_miss = 1; end
      else if (m_state == 3) begin
        m_miss++;
        if (m_miss >= 5) m_state = 0;
      end
    end else begin
      m_ru = u; m_rd = d;
      if (m_state == 0 || !cons) begin
        m_state = 1; m_cnt = 1;
      end else begin
        if (m_state == 1) m_cnt++;
        if (m_state != 1 || m_cnt >= 3) begin
          m_state = 2; m_miss = 0; m_top = u; m_bot = d;
        end
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        m_n++;
        m_fd = 0;
        if (m_pend != 0) begin
          m_pend = 0;
          m_cp = m_cc;
          if (pv && int'(pr) > int'(pl) + 9) begin
            m_hs = int'(pl) + 4; m_he = int'(pr) - 4; m_cc = 1;
          end else begin
            m_hs = 0; m_he = 639; m_cc = 0;
          end
        end
        if (m_n == m_tgt) begin
          m_fd = 1;
          m_sample(int'(pu), int'(pd));
          m_tgt = -1;
        end
        if (vs && m_prev_vs == 0) begin
          m_pend = 1;
          m_tgt = m_n + DLY;
        end
        m_prev_vs = int'(vs);
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("horizon_start", 32'(hs), m_hs);
      chk("horizon_end", 32'(he), m_he);
      chk("ctrl_state", 32'(cstate), m_state);
      chk("char_valid", 32'(cvalid), (m_state >= 2) ? 1 : 0);
      chk("char_top", 32'(ctop), m_top);
      chk("char_bottom", 32'(cbot), m_bot);
      chk("frame_done", 32'(fdone), m_fd);
    end
  end

  task automatic frame(input bit v, input int l, input int r,
                       input int u, input int d, input int len);
    @(negedge clk);
    pv = v; pl = 10'(l); pr = 10'(r); pu = 10'(u); pd = 10'(d); vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    repeat (len - 2) @(negedge clk);
  endtask

  int fd_count;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hs", 32'(hs), 0);
    chk("rst_he", 32'(he), 639);
    chk("rst_state", 32'(cstate), 0);
    chk("rst_valid", 32'(cvalid), 0);
    rst_n = 1'b1;

    frame(1, 100, 400, 50, 90, 12);
    chk("win_start", 32'(hs), 104);
    chk("win_end", 32'(he), 396);
    chk("frame0_bad", 32'(cstate), 0);
    frame(1, 100, 400, 50, 90, 12);
    chk("acq1", 32'(cstate), 1);
    frame(1, 100, 400, 51, 91, 12);
    chk("acq2", 32'(cstate), 1);
    frame(1, 100, 400, 52, 92, 12);
    chk("lock_state", 32'(cstate), 2);
    chk("lock_valid", 32'(cvalid), 1);
    chk("lock_top", 32'(ctop), 52);
    chk("lock_bot", 32'(cbot), 92);

    frame(1, 100, 400, 90, 50, 12);
    frame(1, 100, 400, 90, 50, 12);
    chk("hold_state", 32'(cstate), 3);
    chk("hold_top", 32'(ctop), 52);
    chk("hold_valid", 32'(cvalid), 1);
    frame(1, 100, 400, 53, 93, 12);
    chk("relock_state", 32'(cstate), 2);
    chk("relock_top", 32'(ctop), 53);
    chk("relock_bot", 32'(cbot), 93);

    for (int i = 0; i < 4; i++) frame(1, 100, 400, 90, 50, 12);
    chk("miss4_state", 32'(cstate), 3);
    frame(1, 100, 400, 90, 50, 12);
    chk("lost_state", 32'(cstate), 0);
    chk("lost_valid", 32'(cvalid), 0);

    frame(1, 100, 400, 60, 100, 12);
    frame(1, 100, 400, 61, 101, 12);
    frame(1, 100, 400, 62, 102, 12);
    chk("lock2_state", 32'(cstate), 2);
    frame(1, 100, 400, 120, 170, 12);
    chk("incons_state", 32'(cstate), 1);
    chk("incons_valid", 32'(cvalid), 0);

    frame(0, 100, 400, 120, 170, 12);
    chk("nopl_start", 32'(hs), 0);
    chk("nopl_end", 32'(he), 639);
    frame(1, 100, 108, 121, 171, 12);
    chk("narrow_end", 32'(he), 639);
    chk("nopl_bad", 32'(cstate), 0);
    frame(1, 100, 400, 60, 100, 12);
    chk("narrow_bad", 32'(cstate), 0);

    // Two vsync rises two cycles apart: the first sample must be dropped.
    fd_count = 0;
    @(negedge clk);
    pu = 10'd60; pd = 10'd100; vs = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) vs = 1'b0;
      if (i == 1) vs = 1'b1;
      if (i == 2) vs = 1'b0;
      fd_count += int'(fdone);
    end
    chk("double_vs_done", fd_count, 1);
    chk("double_vs_state", 32'(cstate), 1);

    frame(1, 100, 400, 61, 101, 12);
    frame(1, 100, 400, 62, 102, 12);
    chk("pre_rst_state", 32'(cstate), 2);
    @(negedge clk);
    vs = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(cstate), 0);
    chk("midrst_valid", 32'(cvalid), 0);
    chk("midrst_top", 32'(ctop), 0);
    chk("midrst_end", 32'(he), 639);
    chk("midrst_start", 32'(hs), 0);
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 150; i++) begin
      int r, u, d, len, l;
      r = int'($urandom_range(99, 0));
      l = int'($urandom_range(300, 0));
      if (r < 70) begin
        u = 100 + int'($urandom_range(4, 0));
        d = 150 + int'($urandom_range(4, 0));
      end else if (r < 85) begin
        u = int'($urandom_range(400, 0));
        d = u + int'($urandom_range(250, 0));
      end else begin
        d = int'($urandom_range(300, 0));
        u = d + int'($urandom_range(20, 0));
      end
      len = ($urandom_range(9, 0) == 0) ? int'($urandom_range(4, 2)) : 12;
      frame($urandom_range(9, 0) != 0, l, l + int'($urandom_range(300, 0)),
            u & 1023, d & 1023, len);
    end
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_projection_ctrl.md
# char_projection_ctrl

Frame-level controller for the character horizontal-projection datapath in the plate-recognition pipeline. Each frame it takes the plate column bounds from the plate locator and drives the projection column window, latched at frame boundaries. At the next frame boundary it samples the projection's upper and lower character rows, validates them and tracks them across frames. It publishes a debounced character band (`char_top`/`char_bottom`/`char_valid`) to the character segmentation stage.

## Interface
- `IMG_HDISP`, 640, image width in pixels
- `IMG_VDISP`, 480, image height in lines
- `MARGIN`, 4, columns trimmed from each side of the plate window
- `MIN_HEIGHT`, 10, minimum accepted band height (down−up)
- `MAX_HEIGHT`, 200, maximum accepted band height
- `TOL`, 4, max per-edge row difference for two measurements to count as consistent
- `STABLE_FRAMES`, 3, consecutive consistent good frames needed to lock (≥1)
- `LOST_FRAMES`, 5, consecutive bad frames tolerated in HOLD (≥1)
- `SAMPLE_DLY`, 4, cycles from vsync rising edge to result sampling

Ports:
- `clk` in 1 — pixel clock
- `rst_n` in 1 — reset, asynchronous, active-low
- `per_frame_vsync` in 1 — frame vsync of the stream feeding the projection
- `plate_valid` in 1 — plate locator bounds valid
- `plate_left` in 10 — plate left column
- `plate_right` in 10 — plate right column
- `proj_line_up` in 10 — projection upper row result
- `proj_line_down` in 10 — projection lower row result
- `horizon_start` out 10 — projection window start column
- `horizon_end` out 10 — projection window end column
- `char_top` out 10 — published band top row
- `char_bottom` out 10 — published band bottom row
- `char_valid` out 1 — band published and trusted
- `ctrl_state` out 2 — FSM state, for debug
- `frame_done` out 1 — one-cycle pulse on each sample cycle

## Operation
- Register vsync once. Rising edge (`vs_r & ~vs_r2`) = frame boundary event `fb`.
- At `fb`:
  - `cfg_prev` ← `cfg_cur`.
  - If `plate_valid` and `plate_right` > `plate_left`+2·MARGIN+1: `horizon_start`=`plate_left`+MARGIN, `horizon_end`=`plate_right`−MARGIN, and `cfg_cur`=1.
  - Otherwise `horizon_start`=0, `horizon_end`=IMG_HDISP−1, and `cfg_cur`=0.
- Window registers change only at `fb`. Plate inputs are ignored at all other times.
- Sample timer starts at `fb` and reaches SAMPLE_DLY−1 on the sample cycle. The projection results are stable 3 cycles after the vsync rise.
- On the sample cycle, with u=`proj_line_up` and d=`proj_line_down`:
  - good = `cfg_prev` & d>u & MIN_HEIGHT ≤ d−u ≤ MAX_HEIGHT & d<IMG_VDISP.
  - cons = |u−ref_u| ≤ TOL & |d−ref_d| ≤ TOL, using 11-bit unsigned abs diff.
- Whenever the transition text says ref←meas, ref_u/ref_d are loaded with u/d.
- FSM, evaluated on the sample cycle only. States: IDLE=0, ACQUIRE=1, LOCKED=2, HOLD=3.
  - IDLE, good: ref←meas, cnt=1. Go LOCKED if STABLE_FRAMES==1, else ACQUIRE.
  - IDLE, bad: stay.
  - ACQUIRE, good&cons: cnt++, ref←meas. When cnt+1==STABLE_FRAMES go LOCKED.
  - ACQUIRE, good&!cons: cnt=1, ref←meas.
  - ACQUIRE, bad: go IDLE, cnt=0.
  - LOCKED, good&cons: ref←meas.
  - LOCKED, good&!cons: go ACQUIRE, cnt=1, ref←meas.
  - LOCKED, bad: go HOLD, miss=1.
  - HOLD, good&cons: go LOCKED, miss=0, ref←meas.
  - HOLD, good&!cons: go ACQUIRE, cnt=1, ref←meas.
  - HOLD, bad: miss++. When miss+1==LOST_FRAMES go IDLE.
- Entering LOCKED from any state, and every LOCKED good&cons cycle: `char_top`←u, `char_bottom`←d.
- `char_valid` = 1 in LOCKED or HOLD, else 0. `char_top`/`char_bottom` hold their last values outside updates.

## Timing
- Reset values:
  - `horizon_start`=0, `horizon_end`=IMG_HDISP−1.
  - `char_top`=`char_bottom`=0, `char_valid`=0.
  - `ctrl_state`=IDLE, `frame_done`=0.
  - `cfg_cur`=`cfg_prev`=0, all counters 0, timer idle.
- Window update: outputs change on the edge after the registered vsync rise, i.e. 2 clocks after input vsync rises.
- `frame_done` is asserted SAMPLE_DLY cycles after `fb`. State and char outputs update on the same edge that asserts `frame_done`.
- A new `fb` before the timer expires restarts the timer. The pending sample is dropped with no FSM update and no `frame_done`.
- The first frame after reset has `cfg_prev`=0, so its measurement is always bad.
- Reset mid-frame returns everything to reset values immediately.
- cnt and miss counters saturate and never wrap.

## Structure
- Shared package `char_proj_pkg`: state encoding localparams, width constant `PIX_W`=10.
- One sub-module `frame_sample_timer`: vsync edge detect plus SAMPLE_DLY counter, outputs `fb` and `sample`.

## Test plan
- Reset, plate 100..400 valid at frame 0 → `horizon_start`=104, `horizon_end`=396 from cycle fb+1. Frame-1 sample is good; frame-0 sample is bad (`cfg_prev`=0).
- Three consistent frames u/d = 50/90, 51/91, 52/92 → ACQUIRE, ACQUIRE, LOCKED. `char_valid`=1, `char_top`=52, `char_bottom`=92.
- LOCKED, then 2 bad frames (d<u), then good 53/93 → HOLD, HOLD, LOCKED. Outputs held at 52/92 through HOLD, then 53/93.
- LOCKED, then 5 bad frames → IDLE on the 5th sample, `char_valid`=0.
- LOCKED, then good 120/170 (inconsistent) → ACQUIRE with cnt=1, `char_valid`=0.
- plate_valid=0, or plate 100..108 → window 0..639, next-frame sample treated as bad. A second vsync rise 2 cycles after `fb` → no `frame_done` for the dropped sample.
